apb_decoder: RTL and testbench
==============================

APB_DECODER -- requirements
Module: apb_decoder

Interface
REQ-001 The block SHALL have parameter N_TGT, default 4, meaning the number of downstream APB targets; legal range is 1..16.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum number of ACCESS cycles to wait for m_pready; legal range is 1..1023.
REQ-003 The block SHALL have these ports:
- clk  in  1  clock; one clock domain, all logic on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- s_paddr  in  32  upstream address.
- s_psel  in  1  upstream select.
- s_penable  in  1  upstream enable.
- s_pwrite  in  1  upstream write.
- s_pwdata  in  32  upstream write data.
- s_prdata  out  32  upstream read data.
- s_pready  out  1  upstream ready.
- s_pslverr  out  1  upstream error.
- m_psel  out  N_TGT  one-hot select per target.
- m_penable  out  1  downstream enable.
- m_paddr  out  32  downstream address, registered.
- m_pwrite  out  1  downstream write, registered.
- m_pwdata  out  32  downstream write data, registered.
- m_prdata  in  N_TGT*32  per-target read data; target i occupies bits [32i+31:32i].
- m_pready  in  N_TGT  per-target ready.
- m_pslverr  in  N_TGT  per-target error.
- timeout_flag  out  1  sticky; set when any timeout has occurred.
- err_cnt  out  8  saturating count of error responses returned upstream.

Function
REQ-004 Decode SHALL use tgt = s_paddr[15:12]; the address is mapped iff tgt < N_TGT and s_paddr[31:16] == 0, otherwise it is unmapped.
REQ-005 The FSM SHALL have states IDLE, MSETUP, MACCESS, RESP; the reset state is IDLE.
REQ-006 In IDLE, when s_psel=1 and s_penable=0, the block SHALL capture paddr, pwrite, pwdata and tgt:
- mapped address: go to MSETUP;
- unmapped address: go to RESP with the error bit set and the response data 0.
REQ-007 In MSETUP the block SHALL drive m_psel[tgt]=1 and m_penable=0, then go to MACCESS on the next cycle.
REQ-008 In MACCESS the block SHALL drive m_psel[tgt]=1 and m_penable=1, and increment the timeout counter by 1 each cycle; the counter clears on entry to MSETUP.
REQ-009 In MACCESS, when m_pready[tgt]=1, the block SHALL register m_prdata[tgt] and m_pslverr[tgt] and go to RESP.
REQ-010 In MACCESS, when the counter reaches TIMEOUT with m_pready[tgt]=0, the block SHALL:
- go to RESP with the error bit set and the response data 0;
- set timeout_flag;
- deassert m_psel and m_penable on the next cycle.
REQ-011 If m_pready[tgt] and the timeout condition occur in the same cycle, the pready response SHALL take precedence and timeout_flag SHALL NOT be set.
REQ-012 In RESP the block SHALL drive s_pready=1, s_prdata=captured data and s_pslverr=captured error for exactly one cycle, then return to IDLE.
REQ-013 Outside RESP, s_pready, s_pslverr and s_prdata SHALL be 0.
REQ-014 Outside MSETUP and MACCESS, m_psel and m_penable SHALL be 0.
REQ-015 m_psel SHALL be one-hot or zero at all times.
REQ-016 Downstream signals SHALL be driven only from the captured values; upstream changes after capture SHALL have no effect.
REQ-017 If s_psel drops mid-transaction (protocol violation), the block SHALL still complete the downstream transfer and still pulse s_pready.
REQ-018 A new capture SHALL occur only in IDLE; back-to-back transfers therefore have a minimum of one IDLE cycle between them.
REQ-019 err_cnt SHALL increment by 1 on each RESP cycle with s_pslverr=1 and saturate at 255.
REQ-020 Latency, counting T0 as the upstream setup cycle:
- mapped zero-wait target: MSETUP at T1, MACCESS at T2, s_pready=1 at T3;
- each target wait state adds one cycle;
- unmapped address: s_pready=1 at T1.

Reset
REQ-021 When rst_n=0 at a rising edge, the block SHALL on that edge:
- enter IDLE;
- clear the timeout counter, the capture registers, timeout_flag and err_cnt;
- drive every output to 0.
REQ-022 A reset asserted mid-transaction SHALL drop m_psel and m_penable on the same edge, and no s_pready SHALL be generated for the aborted transfer.
REQ-023 timeout_flag SHALL clear only on reset.

Verification
REQ-024 Write 0x0000_2010 with data 0xA5A5_0001, target 2 zero-wait -> m_psel=4'b0100 at T1-T2, m_penable=1 at T2, m_pwdata=0xA5A5_0001, s_pready=1 and s_pslverr=0 at T3.
REQ-025 Read 0x0000_1004, target 1 with 3 wait states returning 0x1234_5678 -> s_prdata=0x1234_5678 with s_pready=1 at T6; err_cnt unchanged.
REQ-026 Read 0x0001_0000 (unmapped) -> no m_psel activity; s_pready=1, s_pslverr=1, s_prdata=0 at T1; err_cnt=1.
REQ-027 TIMEOUT=4, target 0 never ready -> 4 MACCESS cycles, then s_pslverr=1 and timeout_flag=1; timeout_flag stays 1 through later good transfers.
REQ-028 rst_n=0 during MACCESS of target 3 -> next edge: m_psel=0 and all outputs 0; no s_pready; the next transfer after reset completes normally.
REQ-029 m_pslverr[1]=1 on 300 consecutive reads -> err_cnt saturates at 255.

Source files
------------

// File: rtl/apb_decoder.sv
// APB address decoder bridging one upstream APB requester to N_TGT downstream targets,
// with a per-transfer ACCESS timeout, a sticky timeout flag and a saturating error counter.
module apb_decoder #(
  parameter int N_TGT   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           s_paddr,
  input  logic                  s_psel,
  input  logic                  s_penable,
  input  logic                  s_pwrite,
  input  logic [31:0]           s_pwdata,
  output logic [31:0]           s_prdata,
  output logic                  s_pready,
  output logic                  s_pslverr,
  output logic [N_TGT-1:0]      m_psel,
  output logic                  m_penable,
  output logic [31:0]           m_paddr,
  output logic                  m_pwrite,
  output logic [31:0]           m_pwdata,
  input  logic [N_TGT*32-1:0]   m_prdata,
  input  logic [N_TGT-1:0]      m_pready,
  input  logic [N_TGT-1:0]      m_pslverr,
  output logic                  timeout_flag,
  output logic [7:0]            err_cnt
);

  localparam int TW = (N_TGT > 1) ? $clog2(N_TGT) : 1;
  localparam int CW = 10;

  typedef enum logic [1:0] {IDLE, MSETUP, MACCESS, RESP} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [TW-1:0]   tgt;

  logic [3:0]       addr_tgt;
  logic [TW-1:0]    addr_tgt_w;
  logic             mapped;
  logic [N_TGT-1:0] onehot;
  logic             sel_ready;
  logic             sel_err;
  logic [31:0]      sel_rdata;

  assign addr_tgt   = s_paddr[15:12];
  assign addr_tgt_w = s_paddr[12 +: TW];
  assign mapped     = (s_paddr[31:16] == 16'd0) && (32'(addr_tgt) < 32'(N_TGT));

  always_comb begin
    onehot = '0;
    for (int i = 0; i < N_TGT; i++) begin
      onehot[i] = (addr_tgt_w == TW'(i));
    end
  end

  // Response signals of the captured target only; other targets are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < N_TGT; i++) begin
      if (tgt == TW'(i)) begin
        sel_ready = m_pready[i];
        sel_err   = m_pslverr[i];
        sel_rdata = m_prdata[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      tgt          <= '0;
      s_prdata     <= '0;
      s_pready     <= 1'b0;
      s_pslverr    <= 1'b0;
      m_psel       <= '0;
      m_penable    <= 1'b0;
      m_paddr      <= '0;
      m_pwrite     <= 1'b0;
      m_pwdata     <= '0;
      timeout_flag <= 1'b0;
      err_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s_psel && !s_penable) begin
            m_paddr  <= s_paddr;
            m_pwrite <= s_pwrite;
            m_pwdata <= s_pwdata;
            tgt      <= addr_tgt_w;
            if (mapped) begin
              state  <= MSETUP;
              m_psel <= onehot;
              cnt    <= '0;
            end else begin
              state     <= RESP;
              s_pready  <= 1'b1;
              s_pslverr <= 1'b1;
              s_prdata  <= '0;
            end
          end
        end
        MSETUP: begin
          state     <= MACCESS;
          m_penable <= 1'b1;
        end
        // A ready in the final allowed cycle wins over the timeout.
        MACCESS: begin
          if (sel_ready) begin
            state     <= RESP;
            m_psel    <= '0;
            m_penable <= 1'b0;
            s_pready  <= 1'b1;
            s_pslverr <= sel_err;
            s_prdata  <= sel_rdata;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            state        <= RESP;
            m_psel       <= '0;
            m_penable    <= 1'b0;
            s_pready     <= 1'b1;
            s_pslverr    <= 1'b1;
            s_prdata     <= '0;
            timeout_flag <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          state     <= IDLE;
          s_pready  <= 1'b0;
          s_pslverr <= 1'b0;
          s_prdata  <= '0;
          if (s_pslverr && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_decoder.sv
// Self-checking bench for apb_decoder: directed and randomized APB transfers against
// a transaction-level latency/response model and a simple wait-state target model.
module tb_apb_decoder;

  localparam int N_TGT   = 4;
  localparam int TIMEOUT = 4;
  localparam int NEVER   = 100000;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [31:0]           s_paddr;
  logic                  s_psel;
  logic                  s_penable;
  logic                  s_pwrite;
  logic [31:0]           s_pwdata;
  logic [31:0]           s_prdata;
  logic                  s_pready;
  logic                  s_pslverr;
  logic [N_TGT-1:0]      m_psel;
  logic                  m_penable;
  logic [31:0]           m_paddr;
  logic                  m_pwrite;
  logic [31:0]           m_pwdata;
  logic [N_TGT*32-1:0]   m_prdata;
  logic [N_TGT-1:0]      m_pready;
  logic [N_TGT-1:0]      m_pslverr;
  logic                  timeout_flag;
  logic [7:0]            err_cnt;

  always #5 clk = ~clk;

  apb_decoder #(.N_TGT(N_TGT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_paddr(s_paddr), .s_psel(s_psel), .s_penable(s_penable),
    .s_pwrite(s_pwrite), .s_pwdata(s_pwdata),
    .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
    .m_psel(m_psel), .m_penable(m_penable), .m_paddr(m_paddr),
    .m_pwrite(m_pwrite), .m_pwdata(m_pwdata),
    .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
    .timeout_flag(timeout_flag), .err_cnt(err_cnt)
  );

  // Downstream targets: each answers after tgt_waits[i] wait states of ACCESS.
  int          tgt_waits [N_TGT];
  logic [31:0] tgt_rdata [N_TGT];
  logic        tgt_err   [N_TGT];
  int          wcnt      [N_TGT];

  always @(posedge clk) begin
    for (int i = 0; i < N_TGT; i++) begin
      if (m_psel[i] && m_penable && !m_pready[i]) wcnt[i] <= wcnt[i] + 1;
      else                                        wcnt[i] <= 0;
    end
  end

  always_comb begin
    m_pready  = '0;
    m_pslverr = '0;
    m_prdata  = '0;
    for (int i = 0; i < N_TGT; i++) begin
      m_pready[i]          = m_psel[i] && m_penable && (wcnt[i] == tgt_waits[i]);
      m_pslverr[i]         = tgt_err[i];
      m_prdata[32*i +: 32] = tgt_rdata[i];
    end
  end

  int   checks = 0;
  int   errors = 0;
  int   exp_errcnt = 0;
  logic exp_tflag = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".m_psel"},       32'(m_psel), 32'h0);
    checkOutput({tag, ".m_penable"},    32'(m_penable), 32'h0);
    checkOutput({tag, ".s_pready"},     32'(s_pready), 32'h0);
    checkOutput({tag, ".s_pslverr"},    32'(s_pslverr), 32'h0);
    checkOutput({tag, ".s_prdata"},     s_prdata, 32'h0);
    checkOutput({tag, ".m_paddr"},      m_paddr, 32'h0);
    checkOutput({tag, ".m_pwdata"},     m_pwdata, 32'h0);
    checkOutput({tag, ".m_pwrite"},     32'(m_pwrite), 32'h0);
    checkOutput({tag, ".timeout_flag"}, 32'(timeout_flag), 32'h0);
    checkOutput({tag, ".err_cnt"},      32'(err_cnt), 32'h0);
  endtask

  // One upstream transfer; expected timing and response come from the transaction model.
  task automatic applyStimulus(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                               input bit drop_psel);
    logic [3:0]       t;
    bit               mapped;
    int               lat;
    bit               exp_err;
    bit               tmo;
    logic [31:0]      exp_rd;
    logic [N_TGT-1:0] exp_sel;
    int               new_errcnt;
    t      = addr[15:12];
    mapped = (addr[31:16] == 16'h0) && (int'(t) < N_TGT);
    tmo    = 1'b0;
    if (!mapped) begin
      lat = 1; exp_err = 1'b1; exp_rd = 32'h0;
    end else if (tgt_waits[t] >= TIMEOUT) begin
      lat = TIMEOUT + 2; exp_err = 1'b1; exp_rd = 32'h0; tmo = 1'b1;
    end else begin
      lat = tgt_waits[t] + 3; exp_err = tgt_err[t]; exp_rd = tgt_rdata[t];
    end
    exp_sel    = mapped ? (N_TGT'(1) << t) : '0;
    new_errcnt = exp_err ? ((exp_errcnt < 255) ? exp_errcnt + 1 : 255) : exp_errcnt;

    @(negedge clk);
    s_paddr = addr; s_pwrite = wr; s_pwdata = wdata; s_psel = 1'b1; s_penable = 1'b0;
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      checkOutput("s_pready",  32'(s_pready),  32'(c == lat));
      checkOutput("s_pslverr", 32'(s_pslverr), 32'((c == lat) && exp_err));
      checkOutput("s_prdata",  s_prdata,       (c == lat) ? exp_rd : 32'h0);
      checkOutput("m_psel",    32'(m_psel),    (c < lat) ? 32'(exp_sel) : 32'h0);
      checkOutput("m_penable", 32'(m_penable), 32'(mapped && (c >= 2) && (c < lat)));
      if (c < lat) begin
        checkOutput("m_paddr",  m_paddr,  addr);
        checkOutput("m_pwdata", m_pwdata, wdata);
        checkOutput("m_pwrite", 32'(m_pwrite), 32'(wr));
      end
      checkOutput("timeout_flag", 32'(timeout_flag), 32'(exp_tflag | (tmo && (c >= lat))));
      checkOutput("err_cnt", 32'(err_cnt), (c == lat + 1) ? 32'(new_errcnt) : 32'(exp_errcnt));
      if (c == 1) begin
        s_penable = 1'b1;
        s_paddr   = $urandom;
        s_pwdata  = $urandom;
        s_pwrite  = ~wr;
        if (drop_psel) s_psel = 1'b0;
      end
      if (c == lat) begin
        s_psel = 1'b0; s_penable = 1'b0;
      end
    end
    exp_tflag  = exp_tflag | tmo;
    exp_errcnt = new_errcnt;
  endtask

  task automatic setTarget(input int i, input int waits, input logic [31:0] rdata, input logic err);
    tgt_waits[i] = waits; tgt_rdata[i] = rdata; tgt_err[i] = err;
  endtask

  initial begin
    logic [31:0] addr;
    int          w;
    for (int i = 0; i < N_TGT; i++) begin
      setTarget(i, 0, 32'h0, 1'b0);
      wcnt[i] = 0;
    end
    rst_n = 1'b0; s_paddr = '0; s_psel = 1'b0; s_penable = 1'b0; s_pwrite = 1'b0; s_pwdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;

    $display("[TB] directed transfers");
    setTarget(2, 0, 32'hDEAD_0002, 1'b0);
    applyStimulus(32'h0000_2010, 1'b1, 32'hA5A5_0001, 1'b0);
    setTarget(1, 3, 32'h1234_5678, 1'b0);
    applyStimulus(32'h0000_1004, 1'b0, 32'h0, 1'b0);
    applyStimulus(32'h0001_0000, 1'b0, 32'h0, 1'b0);
    applyStimulus(32'h0000_5000, 1'b1, 32'h5555_AAAA, 1'b0);
    setTarget(3, TIMEOUT - 1, 32'hCAFE_0003, 1'b0);
    applyStimulus(32'h0000_3FFC, 1'b0, 32'h0, 1'b0);
    setTarget(0, NEVER, 32'hBAD0_0000, 1'b0);
    applyStimulus(32'h0000_0040, 1'b0, 32'h0, 1'b0);
    setTarget(2, 1, 32'h0F0F_0F0F, 1'b0);
    applyStimulus(32'h0000_2000, 1'b0, 32'h0, 1'b1);
    setTarget(0, TIMEOUT, 32'h1111_1111, 1'b0);
    applyStimulus(32'h0000_0000, 1'b1, 32'h7777_7777, 1'b0);

    $display("[TB] randomized transfers");
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < N_TGT; i++) begin
        w = $urandom_range(0, 6);
        setTarget(i, (w == 6) ? NEVER : w, $urandom, ($urandom_range(0, 3) == 0));
      end
      addr = {(($urandom_range(0, 4) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0),
              4'($urandom_range(0, 5)), 12'($urandom)};
      applyStimulus(addr, 1'($urandom), $urandom, ($urandom_range(0, 4) == 0));
    end

    $display("[TB] reset during access");
    setTarget(3, NEVER, 32'h3333_3333, 1'b0);
    @(negedge clk);
    s_paddr = 32'h0000_3008; s_pwrite = 1'b1; s_pwdata = 32'h0BAD_F00D; s_psel = 1'b1; s_penable = 1'b0;
    @(negedge clk);
    s_penable = 1'b1;
    @(negedge clk);
    checkOutput("mid.m_psel",    32'(m_psel), 32'h8);
    checkOutput("mid.m_penable", 32'(m_penable), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    checkAllZero("midreset");
    s_psel = 1'b0; s_penable = 1'b0;
    rst_n = 1'b1;
    exp_tflag = 1'b0; exp_errcnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("postreset.s_pready", 32'(s_pready), 32'h0);
      checkOutput("postreset.m_psel",   32'(m_psel), 32'h0);
    end
    setTarget(3, 1, 32'h3C3C_3C3C, 1'b0);
    applyStimulus(32'h0000_3010, 1'b0, 32'h0, 1'b0);

    $display("[TB] error counter saturation");
    setTarget(1, 0, 32'hEEEE_0001, 1'b1);
    for (int n = 0; n < 300; n++) begin
      applyStimulus(32'h0000_1000 + 32'(n % 16) * 4, 1'b0, 32'h0, 1'b0);
    end
    checkOutput("err_cnt.saturated", 32'(err_cnt), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
